// File: rtl/ad9361_tx_deframer_if.sv
// Beat stream into the tx deframer and decoded sample/status stream out of it.
interface ad9361_tx_deframer_if #(
  parameter int ERR_CNT_W = 16
);
  logic                 r1_mode;
  logic                 in_valid;
  logic                 in_frame;
  logic [5:0]           in_data;
  logic                 out_valid;
  logic [11:0]          out_i0;
  logic [11:0]          out_q0;
  logic [11:0]          out_i1;
  logic [11:0]          out_q1;
  logic                 locked;
  logic                 frame_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output r1_mode, in_valid, in_frame, in_data,
    input  out_valid, out_i0, out_q0, out_i1, out_q1, locked, frame_err, err_count
  );

  modport slave (
    input  r1_mode, in_valid, in_frame, in_data,
    output out_valid, out_i0, out_q0, out_i1, out_q1, locked, frame_err, err_count
  );
endinterface

// File: rtl/ad9361_tx_deframer.sv
// Rebuilds 12-bit I/Q samples from the AD9361 6-bit tx beat stream, tracking
// frame alignment and counting framing violations.
module ad9361_tx_deframer #(
  parameter int LOCK_FRAMES = 2,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  ad9361_tx_deframer_if.slave  bus
);
  localparam logic [1:0] SEEK = 2'd0;
  localparam logic [1:0] SYNC = 2'd1;
  localparam logic [1:0] LOCK = 2'd2;
  localparam int GW = $clog2(LOCK_FRAMES + 1);

  logic [1:0]           r_state;
  logic                 r_mode;
  logic                 r_prev_frame;
  logic [2:0]           r_idx;
  logic [GW-1:0]        r_good;
  logic [7:0][5:0]      r_shadow;
  logic                 r_out_valid;
  logic                 r_frame_err;
  logic                 r_locked;
  logic [11:0]          r_i0, r_q0, r_i1, r_q1;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic                 w_tracking;
  logic                 w_exp_frame;
  logic [2:0]           w_last_idx;
  logic                 w_mismatch;
  logic                 w_complete;
  logic [GW-1:0]        w_good_nxt;
  logic [7:0][5:0]      w_beats;

  assign w_tracking  = (r_state != SEEK);
  assign w_last_idx  = r_mode ? 3'd3 : 3'd7;
  assign w_exp_frame = r_mode ? (r_idx < 3'd2) : (r_idx < 3'd4);
  assign w_mismatch  = bus.in_valid && w_tracking && (bus.in_frame != w_exp_frame);
  assign w_complete  = bus.in_valid && w_tracking && !w_mismatch && (r_idx == w_last_idx);
  assign w_good_nxt  = r_good + 1'b1;

  // The final beat is merged combinationally so the frame lands in one edge.
  always_comb begin
    w_beats        = r_shadow;
    w_beats[r_idx] = bus.in_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= SEEK;
      r_mode       <= 1'b0;
      r_prev_frame <= 1'b1;
      r_idx        <= 3'd0;
      r_good       <= '0;
      r_shadow     <= '0;
      r_out_valid  <= 1'b0;
      r_frame_err  <= 1'b0;
      r_locked     <= 1'b0;
      r_i0         <= '0;
      r_q0         <= '0;
      r_i1         <= '0;
      r_q1         <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_state == SEEK) r_mode <= bus.r1_mode;
      if (bus.in_valid) begin
        r_prev_frame <= bus.in_frame;
        if (r_state == SEEK) begin
          if (bus.in_frame && !r_prev_frame) begin
            r_state     <= SYNC;
            r_good      <= '0;
            r_idx       <= 3'd1;
            r_shadow[0] <= bus.in_data;
          end
        end else if (w_mismatch) begin
          r_state     <= SEEK;
          r_locked    <= 1'b0;
          r_idx       <= 3'd0;
          r_frame_err <= 1'b1;
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
        end else begin
          r_shadow[r_idx] <= bus.in_data;
          if (w_complete) begin
            r_idx       <= 3'd0;
            r_out_valid <= 1'b1;
            r_i0 <= r_mode ? {w_beats[0], w_beats[2]} : {w_beats[0], w_beats[4]};
            r_q0 <= r_mode ? {w_beats[1], w_beats[3]} : {w_beats[1], w_beats[5]};
            r_i1 <= r_mode ? 12'd0 : {w_beats[2], w_beats[6]};
            r_q1 <= r_mode ? 12'd0 : {w_beats[3], w_beats[7]};
            if (r_state == SYNC) begin
              if (w_good_nxt == GW'(LOCK_FRAMES)) begin
                r_state  <= LOCK;
                r_locked <= 1'b1;
              end else begin
                r_good <= w_good_nxt;
              end
            end
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_i0    = r_i0;
  assign bus.out_q0    = r_q0;
  assign bus.out_i1    = r_i1;
  assign bus.out_q1    = r_q1;
  assign bus.locked    = r_locked;
  assign bus.frame_err = r_frame_err;
  assign bus.err_count = r_err_cnt;
endmodule

// File: tb/tb_ad9361_tx_deframer.sv
// Bench for ad9361_tx_deframer: vector table plus hand sequences, scoreboarded outputs.
module tb_ad9361_tx_deframer;
  localparam int EW = 3;

  typedef logic [7:0][5:0] beats_t;
  typedef struct { logic m; logic [11:0] i0, q0, i1, q1; } exp_t;
  typedef struct { logic m; beats_t b; logic [11:0] i0, q0, i1, q1; } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ad9361_tx_deframer_if #(.ERR_CNT_W(EW)) bus();
  ad9361_tx_deframer #(.LOCK_FRAMES(2), .ERR_CNT_W(EW)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  exp_t sb[$];
  exp_t mon_e;
  vec_t tv[5];
  int total = 0, bad = 0, cyc = 0;
  int ov_cnt = 0, fe_cnt = 0, ov_cyc = -1, fe_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      ov_cnt++;
      ov_cyc = cyc;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: out_valid=1 got, none expected (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("sb_i0", 32'(bus.out_i0), 32'(mon_e.i0));
        check("sb_q0", 32'(bus.out_q0), 32'(mon_e.q0));
        if (mon_e.m == 1'b0) begin
          check("sb_i1", 32'(bus.out_i1), 32'(mon_e.i1));
          check("sb_q1", 32'(bus.out_q1), 32'(mon_e.q1));
        end
      end
    end
    if (bus.frame_err === 1'b1) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
  end

  function automatic beats_t mk(input logic [5:0] b0, b1, b2, b3, b4, b5, b6, b7);
    return {b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic f, input logic [5:0] d);
    bus.in_valid = 1'b1;
    bus.in_frame = f;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_frame = ~f;
    bus.in_data  = ~d;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(1);
  endtask

  task automatic send_frame(input logic m, input beats_t b, input int flip, input int gap_after,
                            input int gap_len, input bit push, input logic [11:0] i0, q0, i1, q1,
                            output int c_first, output int c_flip, output int c_last);
    int L;
    logic f;
    exp_t e;
    L = m ? 4 : 8;
    c_flip = -1;
    if (push) begin
      e = '{m, i0, q0, i1, q1};
      sb.push_back(e);
    end
    for (int k = 0; k < L; k++) begin
      f = (k < L / 2);
      if (k == flip) f = ~f;
      beat(f, b[k]);
      if (k == 0) c_first = cyc;
      if (k == flip) c_flip = cyc;
      if (k == gap_after) tick(gap_len);
    end
    c_last = cyc;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, cf, cl, ov0, fe0;
    logic [5:0] d;

    tv[0] = '{1'b0, mk(6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08), 12'h045, 12'h086, 12'h0C7, 12'h108};
    tv[1] = '{1'b1, mk(6'h3F, 6'h00, 6'h01, 6'h2A, 6'h00, 6'h00, 6'h00, 6'h00), 12'hFC1, 12'h02A, 12'h000, 12'h000};
    tv[2] = '{1'b0, mk(6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F), 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    tv[3] = '{1'b0, mk(6'h00, 6'h15, 6'h2A, 6'h3F, 6'h01, 6'h02, 6'h03, 6'h04), 12'h001, 12'h542, 12'hA83, 12'hFC4};
    tv[4] = '{1'b1, mk(6'h12, 6'h34, 6'h05, 6'h3E, 6'h00, 6'h00, 6'h00, 6'h00), 12'h485, 12'hD3E, 12'h000, 12'h000};

    bus.r1_mode = 1'b1; bus.in_valid = 1'b0; bus.in_frame = 1'b0; bus.in_data = 6'd0;
    tick(2);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_locked",    32'(bus.locked), 0);
    check("rst_frame_err", 32'(bus.frame_err), 0);
    check("rst_err_count", 32'(bus.err_count), 0);
    check("rst_out_i0",    32'(bus.out_i0), 0);
    check("rst_out_q1",    32'(bus.out_q1), 0);
    resetn = 1'b1;
    tick(1);

    // vector table: three frames each, locked after the second
    for (int v = 0; v < 5; v++) begin
      do_reset();
      bus.r1_mode = tv[v].m;
      beat(1'b0, 6'd0);
      for (int n = 0; n < 3; n++)
        send_frame(tv[v].m, tv[v].b, -1, -1, 0, 1'b1, tv[v].i0, tv[v].q0, tv[v].i1, tv[v].q1, c0, cf, cl);
      tick(3);
      check("tv_drain",  32'(sb.size()), 0);
      check("tv_locked", 32'(bus.locked), 1);
      check("tv_errs",   32'(bus.err_count), 0);
    end

    // 1R1T counting stream
    do_reset();
    bus.r1_mode = 1'b1;
    beat(1'b0, 6'd0);
    for (int v = 0; v < 1000; v++) begin
      d = 6'(v);
      send_frame(1'b1, {8{d}}, -1, -1, 0, 1'b1, {d, d}, {d, d}, 12'd0, 12'd0, c0, cf, cl);
      if (v == 0) begin
        check("cnt_first_ov", 32'(bus.out_valid), 1);
        check("cnt_lock0",    32'(bus.locked), 0);
      end
      if (v == 1) check("cnt_lock1", 32'(bus.locked), 1);
    end
    tick(3);
    check("cnt_hold",  32'(bus.out_i0), 32'h9E7);
    check("cnt_errs",  32'(bus.err_count), 0);
    check("cnt_drain", 32'(sb.size()), 0);

    // violation on beat 1 while locked, then relock
    fe0 = fe_cnt;
    send_frame(1'b1, mk(6'h11, 6'h22, 6'h33, 6'h2C, 0, 0, 0, 0), 1, -1, 0, 1'b0, 0, 0, 0, 0, c0, cf, cl);
    tick(1);
    check("lk_fe_cyc", 32'(fe_cyc), 32'(cf));
    check("lk_fe_cnt", 32'(fe_cnt - fe0), 1);
    check("lk_unlock", 32'(bus.locked), 0);
    check("lk_err",    32'(bus.err_count), 1);
    send_frame(1'b1, mk(6'h01, 6'h02, 6'h03, 6'h04, 0, 0, 0, 0), -1, -1, 0, 1'b1, 12'h043, 12'h084, 0, 0, c0, cf, cl);
    check("lk_relock0", 32'(bus.locked), 0);
    send_frame(1'b1, mk(6'h01, 6'h02, 6'h03, 6'h04, 0, 0, 0, 0), -1, -1, 0, 1'b1, 12'h043, 12'h084, 0, 0, c0, cf, cl);
    check("lk_relock1", 32'(bus.locked), 1);

    // 5-cycle gap mid-frame; r1_mode flip while locked must be ignored
    bus.r1_mode = 1'b0;
    send_frame(1'b1, mk(6'h2A, 6'h15, 6'h0F, 6'h30, 0, 0, 0, 0), -1, 1, 5, 1'b1, 12'hA8F, 12'h570, 0, 0, c0, cf, cl);
    check("gap_span", 32'(cl - c0), 8);
    tick(1);
    check("gap_ov_cyc", 32'(ov_cyc), 32'(cl));
    check("gap_err",    32'(bus.err_count), 1);
    check("gap_locked", 32'(bus.locked), 1);
    bus.r1_mode = 1'b1;

    // stream starting high after reset
    do_reset();
    ov0 = ov_cnt;
    beat(1'b1, 6'h05); beat(1'b1, 6'h06); beat(1'b0, 6'h07); beat(1'b0, 6'h08);
    tick(2);
    check("sh_no_ov",  32'(ov_cnt - ov0), 0);
    check("sh_locked", 32'(bus.locked), 0);
    send_frame(1'b1, mk(6'h05, 6'h06, 6'h07, 6'h08, 0, 0, 0, 0), -1, -1, 0, 1'b1, 12'h147, 12'h188, 0, 0, c0, cf, cl);
    tick(2);
    check("sh_ov", 32'(ov_cnt - ov0), 1);

    // error counter saturation
    do_reset();
    fe0 = fe_cnt;
    beat(1'b0, 6'd0);
    for (int n = 0; n < 6; n++) begin beat(1'b1, 6'd0); beat(1'b0, 6'd0); end
    tick(1);
    check("sat_pre", 32'(bus.err_count), 6);
    for (int n = 0; n < 3; n++) begin beat(1'b1, 6'd0); beat(1'b0, 6'd0); end
    tick(1);
    check("sat_full", 32'(bus.err_count), 7);
    check("sat_pulses", 32'(fe_cnt - fe0), 9);

    // asynchronous reset mid-frame
    send_frame(1'b1, mk(6'h3F, 6'h3F, 6'h01, 6'h01, 0, 0, 0, 0), -1, -1, 0, 1'b1, 12'hFC1, 12'hFC1, 0, 0, c0, cf, cl);
    beat(1'b1, 6'h2B);
    beat(1'b1, 6'h2C);
    check("ar_pre_i0", 32'(bus.out_i0), 32'hFC1);
    #2;
    resetn = 1'b0;
    #1;
    check("ar_i0",    32'(bus.out_i0), 0);
    check("ar_q0",    32'(bus.out_q0), 0);
    check("ar_err",   32'(bus.err_count), 0);
    check("ar_valid", 32'(bus.out_valid), 0);
    check("ar_lock",  32'(bus.locked), 0);
    tick(2);
    resetn = 1'b1;
    tick(2);
    check("final_drain", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
